// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single cache reads, and buffers returned instructions.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ADD_WIDTH  = 12,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [ADD_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned          PC_INC     = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [ADD_WIDTH-1:0]  cache_add,
  output logic                  cache_ren,
  output logic                  cache_wen,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  input  logic                  hit_miss,
  input  logic [DATA_WIDTH-1:0] cache_data,
  input  logic                  redirect_valid,
  input  logic [ADD_WIDTH-1:0]  redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic [ADD_WIDTH-1:0]  inst_pc,
  output logic [15:0]           perf_hits,
  output logic [15:0]           perf_stall
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_HOLD, S_ISSUE, S_CHECK} state_t;

  state_t                r_state, w_state_next;
  logic [ADD_WIDTH-1:0]  r_pc, w_pc_next;
  logic [ADD_WIDTH-1:0]  r_pend_pc, w_pend_pc_next;
  logic                  r_pend, w_pend_next;
  logic                  r_ren;

  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [ADD_WIDTH-1:0]  r_mem_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr, r_rptr;
  logic [CNT_W-1:0]      r_count, w_count_next;

  logic w_pop, w_capture, w_push, w_space;

  assign w_pop     = (r_count != '0) && inst_ready;
  assign w_capture = (r_state == S_CHECK) && hit_miss;
  // A capture is discarded when a redirect is pending or arriving on the same edge.
  assign w_push    = w_capture && !r_pend && !redirect_valid;

  always_comb begin
    w_count_next = r_count;
    if (redirect_valid) w_count_next = '0;
    else                w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  end

  assign w_space = (w_count_next < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= S_HOLD;
      r_pc      <= RESET_PC;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
      r_ren     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_pc      <= w_pc_next;
      r_pend    <= w_pend_next;
      r_pend_pc <= w_pend_pc_next;
      r_ren     <= (w_state_next != S_HOLD);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_pend_next    = r_pend;
    w_pend_pc_next = r_pend_pc;
    case (r_state)
      S_HOLD: begin
        if (redirect_valid) w_pc_next    = redirect_pc;
        else if (w_space)   w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_state_next = S_CHECK;
        if (redirect_valid) begin
          w_pend_next    = 1'b1;
          w_pend_pc_next = redirect_pc;
        end
      end
      S_CHECK: begin
        if (hit_miss) begin
          w_pend_next  = 1'b0;
          w_state_next = S_ISSUE;
          if (redirect_valid)  w_pc_next = redirect_pc;
          else if (r_pend)     w_pc_next = r_pend_pc;
          else begin
            w_pc_next = r_pc + ADD_WIDTH'(PC_INC);
            if (!w_space) w_state_next = S_HOLD;
          end
        end else if (redirect_valid) begin
          w_pend_next    = 1'b1;
          w_pend_pc_next = redirect_pc;
        end
      end
      default: w_state_next = S_HOLD;
    endcase
  end

  // Show-ahead instruction buffer; a redirect flush overrides any push or pop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem_data[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem_data[r_wptr] <= cache_data;
        r_mem_pc[r_wptr]   <= r_pc;
        r_wptr             <= r_wptr + PTR_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_count_next;
    end
  end

  assign cache_add   = r_pc;
  assign cache_ren   = r_ren;
  assign cache_wen   = 1'b0;
  assign cache_wdata = '0;
  assign inst_valid  = (r_count != '0);
  assign inst_data   = r_mem_data[r_rptr];
  assign inst_pc     = r_mem_pc[r_rptr];

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf_hits, r_perf_stall;

  // Saturating counters: pushed captures and stalled CHECK cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_perf_hits  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push && (r_perf_hits != 16'hFFFF))
        r_perf_hits <= r_perf_hits + 16'd1;
      if ((r_state == S_CHECK) && !hit_miss && (r_perf_stall != 16'hFFFF))
        r_perf_stall <= r_perf_stall + 16'd1;
    end
  end

  assign perf_hits  = r_perf_hits;
  assign perf_stall = r_perf_stall;
`else
  assign perf_hits  = 16'd0;
  assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural cache model plus an instruction scoreboard.
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] cache_add;
  logic        cache_ren, cache_wen;
  logic [31:0] cache_wdata;
  logic        hit_miss;
  logic [31:0] cache_data;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [11:0] inst_pc;
  logic [15:0] perf_hits, perf_stall;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n),
    .cache_add(cache_add), .cache_ren(cache_ren), .cache_wen(cache_wen),
    .cache_wdata(cache_wdata), .hit_miss(hit_miss), .cache_data(cache_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .perf_hits(perf_hits), .perf_stall(perf_stall)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Cache model: k counts cycles the current request has been presented.
  int          k = 0;
  int          miss_lat = 0;
  logic [11:0] miss_addr = 12'h020;
  int          miss_addr_lat = 0;
  logic        stale_hit = 1'b0;

  function automatic logic [31:0] data_of(input logic [11:0] a);
    return {a, 8'h5A, a};
  endfunction

  function automatic int misses_for(input logic [11:0] a);
    return (a == miss_addr) ? miss_addr_lat : miss_lat;
  endfunction

  assign cache_data = data_of(cache_add);
  assign hit_miss   = cache_ren && ((k >= 1 + misses_for(cache_add)) || (stale_hit && k == 0));

  always @(posedge clock) begin
    if (!reset_n || !cache_ren) k <= 0;
    else if (k >= 1 && hit_miss) k <= 0;
    else k <= k + 1;
  end

  logic [43:0] sb[$];

  task automatic do_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 12'h300;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_checks++; if (cache_ren !== 1'b0) $display("FAIL rst_ren got=%b exp=0", cache_ren); else n_pass++;
      n_checks++; if (cache_add !== 12'h000) $display("FAIL rst_add got=%h exp=000", cache_add); else n_pass++;
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", inst_valid); else n_pass++;
    end
    n_checks++; if ({inst_data, inst_pc, perf_hits, perf_stall} !== '0)
      $display("FAIL rst_outs got=%h/%h/%h/%h exp=0", inst_data, inst_pc, perf_hits, perf_stall); else n_pass++;
    @(posedge clock); #1;
    reset_n = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clock);
    n_checks++; if (cache_ren !== 1'b0) $display("FAIL rel_hold got=%b exp=0", cache_ren); else n_pass++;
    @(negedge clock);
    n_checks++; if ({cache_ren, cache_add} !== {1'b1, 12'h000})
      $display("FAIL rel_issue got=%b/%h exp=1/000", cache_ren, cache_add); else n_pass++;
  endtask

  task automatic test_hits();
    int issue_c = -1, first_pop = -1, last_pop = -1;
    logic [43:0] e;
    miss_lat = 0; miss_addr_lat = 0; stale_hit = 1'b1;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back({12'(i * 4), data_of(12'(i * 4))});
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(negedge clock);
      if (cache_ren && issue_c < 0) issue_c = cyc;
      if (inst_valid && inst_ready) begin
        e = sb.pop_front();
        n_checks++; if ({inst_pc, inst_data} !== e)
          $display("FAIL hit_data got=%h/%h exp=%h", inst_pc, inst_data, e); else n_pass++;
        if (first_pop < 0) first_pop = cyc;
        else begin
          n_checks++; if (cyc - last_pop != 2) $display("FAIL hit_gap got=%0d exp=2", cyc - last_pop); else n_pass++;
        end
        last_pop = cyc;
      end
    end
    n_checks++; if (first_pop - issue_c != 2) $display("FAIL hit_latency got=%0d exp=2", first_pop - issue_c); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL hit_drain left=%0d exp=0", sb.size()); else n_pass++;
    inst_ready = 1'b0; stale_hit = 1'b0;
  endtask

  task automatic test_miss();
    int issue_c = -1, first_pop = -1;
    logic [43:0] e;
    logic [15:0] exp_stall, exp_hits;
`ifdef FETCH_PERF_CNT_EN
    exp_stall = 16'd2; exp_hits = 16'd1;
`else
    exp_stall = 16'd0; exp_hits = 16'd0;
`endif
    miss_lat = 2; miss_addr_lat = 2; stale_hit = 1'b1;
    do_reset();
    inst_ready = 1'b1;
    sb.push_back({12'h000, data_of(12'h000)});
    sb.push_back({12'h004, data_of(12'h004)});
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(negedge clock);
      if (cache_ren && issue_c < 0) issue_c = cyc;
      if (issue_c >= 0 && cyc - issue_c < 4) begin
        n_checks++; if ({cache_ren, cache_add} !== {1'b1, 12'h000})
          $display("FAIL miss_hold got=%b/%h exp=1/000", cache_ren, cache_add); else n_pass++;
      end
      if (issue_c >= 0 && cyc - issue_c == 4) begin
        n_checks++; if ({perf_stall, perf_hits} !== {exp_stall, exp_hits})
          $display("FAIL miss_perf got=%0d/%0d exp=%0d/%0d", perf_stall, perf_hits, exp_stall, exp_hits); else n_pass++;
      end
      if (inst_valid && inst_ready) begin
        e = sb.pop_front();
        n_checks++; if ({inst_pc, inst_data} !== e)
          $display("FAIL miss_data got=%h/%h exp=%h", inst_pc, inst_data, e); else n_pass++;
        if (first_pop < 0) first_pop = cyc;
      end
    end
    n_checks++; if (first_pop - issue_c != 4) $display("FAIL miss_latency got=%0d exp=4", first_pop - issue_c); else n_pass++;
    n_checks++; if (sb.size() != 0) $display("FAIL miss_drain left=%0d exp=0", sb.size()); else n_pass++;
    inst_ready = 1'b0; stale_hit = 1'b0; miss_lat = 0; miss_addr_lat = 0;
  endtask

  task automatic test_full();
    logic seen = 1'b0, done = 1'b0;
    logic [43:0] e;
    miss_lat = 0; miss_addr_lat = 0;
    do_reset();
    for (int i = 0; i < 6; i++) sb.push_back({12'(i * 4), data_of(12'(i * 4))});
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clock);
      if (cache_ren) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    n_checks++; if (!done) $display("FAIL full_timeout got=running exp=hold"); else n_pass++;
    n_checks++; if ({cache_add, inst_valid, inst_pc} !== {12'h010, 1'b1, 12'h000})
      $display("FAIL full_hold got=%h/%b/%h exp=010/1/000", cache_add, inst_valid, inst_pc); else n_pass++;
    repeat (2) begin
      @(negedge clock);
      n_checks++; if (cache_ren !== 1'b0) $display("FAIL full_stay got=%b exp=0", cache_ren); else n_pass++;
    end
    @(posedge clock); #1; inst_ready = 1'b1;
    @(negedge clock);
    if (inst_valid && inst_ready) begin
      e = sb.pop_front();
      n_checks++; if ({inst_pc, inst_data} !== e)
        $display("FAIL full_pop got=%h/%h exp=%h", inst_pc, inst_data, e); else n_pass++;
    end
    @(posedge clock); #1; inst_ready = 1'b0;
    @(negedge clock);
    n_checks++; if ({cache_ren, cache_add} !== {1'b1, 12'h010})
      $display("FAIL full_reissue got=%b/%h exp=1/010", cache_ren, cache_add); else n_pass++;
    @(posedge clock); #1; inst_ready = 1'b1;
    for (int c = 0; c < 60 && sb.size() != 0; c++) begin
      @(negedge clock);
      if (inst_valid && inst_ready) begin
        e = sb.pop_front();
        n_checks++; if ({inst_pc, inst_data} !== e)
          $display("FAIL full_data got=%h/%h exp=%h", inst_pc, inst_data, e); else n_pass++;
      end
    end
    n_checks++; if (sb.size() != 0) $display("FAIL full_drain left=%0d exp=0", sb.size()); else n_pass++;
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect();
    logic found = 1'b0, moved = 1'b0;
    logic [43:0] e;
    miss_lat = 0; miss_addr = 12'h020; miss_addr_lat = 3;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 12'h018;
    @(posedge clock); #1; redirect_valid = 1'b0;
    @(negedge clock);
    n_checks++; if ({cache_ren, cache_add} !== {1'b0, 12'h018})
      $display("FAIL redir_hold got=%b/%h exp=0/018", cache_ren, cache_add); else n_pass++;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clock);
      if (cache_add == 12'h020 && k == 1) found = 1'b1;
    end
    n_checks++; if (!found || inst_valid !== 1'b1)
      $display("FAIL redir_setup got=%b/%b exp=1/1", found, inst_valid); else n_pass++;
    @(posedge clock); #1; redirect_valid = 1'b1; redirect_pc = 12'h100;
    @(posedge clock); #1; redirect_valid = 1'b0; redirect_pc = 12'h3FC;
    sb.push_back({12'h100, data_of(12'h100)});
    sb.push_back({12'h104, data_of(12'h104)});
    inst_ready = 1'b1;
    @(negedge clock);
    n_checks++; if ({inst_valid, cache_ren, cache_add} !== {1'b0, 1'b1, 12'h020})
      $display("FAIL redir_flush got=%b/%b/%h exp=0/1/020", inst_valid, cache_ren, cache_add); else n_pass++;
    for (int c = 0; c < 20 && !moved; c++) begin
      @(negedge clock);
      n_checks++; if (inst_valid !== 1'b0) $display("FAIL redir_nopush got=%b exp=0", inst_valid); else n_pass++;
      if (cache_add != 12'h020) moved = 1'b1;
    end
    n_checks++; if ({cache_ren, cache_add} !== {1'b1, 12'h100})
      $display("FAIL redir_target got=%b/%h exp=1/100", cache_ren, cache_add); else n_pass++;
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      @(negedge clock);
      if (inst_valid && inst_ready) begin
        e = sb.pop_front();
        n_checks++; if ({inst_pc, inst_data} !== e)
          $display("FAIL redir_data got=%h/%h exp=%h", inst_pc, inst_data, e); else n_pass++;
      end
    end
    n_checks++; if (sb.size() != 0) $display("FAIL redir_drain left=%0d exp=0", sb.size()); else n_pass++;
    inst_ready = 1'b0; miss_addr_lat = 0;
  endtask

  task automatic test_wrap();
    logic [43:0] e;
    miss_lat = 0; miss_addr_lat = 0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 12'hFFC;
    @(posedge clock); #1; redirect_valid = 1'b0;
    inst_ready = 1'b1;
    sb.push_back({12'hFFC, data_of(12'hFFC)});
    sb.push_back({12'h000, data_of(12'h000)});
    sb.push_back({12'h004, data_of(12'h004)});
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      @(negedge clock);
      if (inst_valid && inst_ready) begin
        e = sb.pop_front();
        n_checks++; if ({inst_pc, inst_data} !== e)
          $display("FAIL wrap_data got=%h/%h exp=%h", inst_pc, inst_data, e); else n_pass++;
        if (e[43:32] == 12'hFFC) begin
          n_checks++; if ({cache_ren, cache_add} !== {1'b1, 12'h000})
            $display("FAIL wrap_issue got=%b/%h exp=1/000", cache_ren, cache_add); else n_pass++;
        end
      end
    end
    n_checks++; if (sb.size() != 0) $display("FAIL wrap_drain left=%0d exp=0", sb.size()); else n_pass++;
    inst_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hits();
    test_miss();
    test_full();
    test_redirect();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction cache. It owns the program counter and issues one read at a time on the cache CPU port. It holds the address steady through the cache's miss/fill/re-lookup sequence. Returned instructions are buffered in a small FIFO with a valid/ready handshake toward decode. A redirect input flushes the buffer and reloads the PC.

## Interface
- DATA_WIDTH, 32, instruction width (matches cache data port)
- ADD_WIDTH, 12, address width (matches cache address port)
- FIFO_DEPTH, 4, instruction buffer entries; power of two, ≥2
- RESET_PC, 0, PC value after reset
- PC_INC, 4, PC increment per fetched instruction
- clock  input  1  single clock; all state updates on posedge
- reset_n  input  1  synchronous, active-low reset
- cache_add  output  ADD_WIDTH  fetch address to cache (= PC register)
- cache_ren  output  1  read request to cache
- cache_wen  output  1  tied 0
- cache_wdata  output  DATA_WIDTH  tied 0
- hit_miss  input  1  cache registered hit flag
- cache_data  input  DATA_WIDTH  cache read data
- redirect_valid  input  1  one-cycle request to fetch from redirect_pc
- redirect_pc  input  ADD_WIDTH  redirect target
- inst_valid  output  1  FIFO head valid
- inst_ready  input  1  decode accepts head
- inst_data  output  DATA_WIDTH  head instruction
- inst_pc  output  ADD_WIDTH  head instruction address
- perf_hits  output  16  completed fetches (see Configuration)
- perf_stall  output  16  CHECK cycles with hit_miss=0 (see Configuration)

## Operation
- States: HOLD (no request), ISSUE (request presented), CHECK (await hit).
- cache_ren=1 in ISSUE and CHECK, 0 in HOLD and during reset. cache_add = pc at all times. pc changes only in HOLD, or on the edge leaving CHECK with a capture.
- HOLD→ISSUE when FIFO not full. Otherwise stay.
- ISSUE→CHECK unconditionally. The cache samples pc at this edge.
- CHECK, hit_miss=0: stay, holding pc and cache_ren. This covers the cache's miss state and the re-lookup.
- CHECK, hit_miss=1: capture. Push {pc, cache_data} into the FIFO and set pc ← pc+PC_INC (modulo 2^ADD_WIDTH, wraps 0xFFC→0x000). Go to ISSUE if the FIFO has space after this push (counting a same-cycle pop), else HOLD.
- hit_miss seen during ISSUE is stale and is ignored.
- Only one request is outstanding at a time, so a push never overflows.
- FIFO: show-ahead. inst_valid = !empty. Pop on inst_valid & inst_ready. Simultaneous push and pop are legal, including at full.
- Redirect in HOLD: flush FIFO, pc ← redirect_pc, stay HOLD. ISSUE follows next cycle.
- Redirect in ISSUE or CHECK: flush FIFO now and latch the target as pending. The transaction finishes with pc held. On hit_miss=1 the data is discarded (no push), pc ← pending target, and the FSM goes to ISSUE. A second redirect before completion overwrites the target.
- Redirect on the same edge as a capture: capture dropped, pc ← redirect_pc.
- Redirect with pop: flush wins.
- Reset mid-miss: pc ← RESET_PC. A cache still in its fill state fills RESET_PC's line with that address's memory data, which is consistent. The FSM restarts from HOLD.

## Timing
- Reset values: state=HOLD, pc=RESET_PC, cache_add=RESET_PC, cache_ren=0, FIFO empty, inst_valid=0, inst_data=0, inst_pc=0, pending redirect cleared, perf counters 0.
- Hit: ISSUE cycle c0, CHECK c1 (hit_miss=1) captures at end of c1, inst_valid=1 in c2. Steady-state throughput is 1 instruction per 2 cycles.
- Miss: ISSUE c0, CHECK c1/c2 with hit_miss=0, c3 with hit_miss=1 captures, inst_valid=1 in c4.
- After reset_n rises: one cycle in HOLD, then ISSUE.

## Configuration
- FETCH_PERF_CNT_EN defined: perf_hits increments on each capture that is pushed. perf_stall increments on each CHECK cycle with hit_miss=0. Both saturate at 0xFFFF and clear on reset.
- FETCH_PERF_CNT_EN not defined: no counter registers; perf_hits and perf_stall are tied 0.

## Test plan
- reset_n=0 for 2 cycles with redirect_valid=1 → cache_ren=0, cache_add=0x000, inst_valid=0. After release: HOLD one cycle, then ISSUE at 0x000.
- Cache model hits everywhere, inst_ready=1 → inst_pc sequence 0x000, 0x004, 0x008, one new entry every 2 cycles, each inst_data matching the model.
- Cold miss at 0x000 (hit_miss 0,0,1 in CHECK) → cache_add held at 0x000 for 4 cycles, inst_valid first high 4 cycles after ISSUE. With the macro defined, perf_stall=2 and perf_hits=1.
- inst_ready=0, all hits → 4 entries (0x000–0x00C), then HOLD with cache_ren=0 and cache_add=0x010. inst_ready=1 for one cycle → ISSUE at 0x010 on the next cycle.
- redirect_valid=1, redirect_pc=0x100 during CHECK of a miss at 0x020 → FIFO empties next cycle, cache_add stays 0x020 until hit_miss=1, that data is never pushed, next ISSUE is at 0x100.
- pc=0xFFC hit → entry inst_pc=0xFFC, next ISSUE at 0x000.
